rr_arb8: RTL
============

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 16: the maximum number of consecutive cycles one grant is held (legal range 2..256).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port req, input, 8 bits: request vector; bit i is requester i, level-sensitive.
REQ-005 The module SHALL have port done, input, 1 bit: single-cycle release from the current grantee.
REQ-006 The module SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-007 The module SHALL have port gnt_id, output, 3 bits: binary index of the granted requester, registered.
REQ-008 The module SHALL have port gnt_valid, output, 1 bit: high while any grant is held; equals the OR of gnt.
REQ-009 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is forcibly revoked at MAX_HOLD.

Function
REQ-010 The module SHALL implement states IDLE (no grant) and GRANT (one grant held), held in a registered state variable.
REQ-011 The module SHALL hold a 3-bit register last containing the index of the most recent grant.
REQ-012 Winner selection SHALL be: masked = req AND (bits strictly below index last); if masked is nonzero, the winner is the highest set bit of masked; otherwise the winner is the highest set bit of req.
REQ-013 In IDLE with req nonzero at edge N, the module SHALL enter GRANT at N+1 with gnt one-hot at the winner, gnt_id equal to the winner, gnt_valid=1, and last updated to the winner (one-cycle latency).
REQ-014 In IDLE with req zero, all outputs SHALL stay 0 and last SHALL be unchanged.
REQ-015 In GRANT, a 9-bit hold counter SHALL clear on grant and increment by 1 each cycle the grant is held.
REQ-016 A release event in GRANT SHALL be any of: done=1; req[gnt_id]=0; or hold count equal to MAX_HOLD-1.
REQ-017 On a release at edge N, if req with the released bit cleared is nonzero, the module SHALL grant the REQ-012 winner at N+1, computed with last = the released index and with the released bit excluded (back-to-back, no idle cycle).
REQ-018 On a release at edge N otherwise, the module SHALL return to IDLE at N+1 with gnt=0.
REQ-019 The module SHALL assert timeout for exactly the cycle after a release caused only by the hold limit.
REQ-020 If done=1 or req[gnt_id]=0 coincides with the hold limit, the release SHALL count as normal and timeout SHALL stay 0.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 Changes to req bits other than the grantee's SHALL NOT affect a held grant.
REQ-023 gnt SHALL never have more than one bit set, and gnt_id SHALL equal 0 whenever gnt_valid=0.

Reset
REQ-024 On rst=1 at a rising edge, the module SHALL set state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, last=0 and hold counter=0, regardless of state, including mid-grant.
REQ-025 rst SHALL take precedence over every release and grant event in the same cycle; the first grant can appear on the edge after rst deasserts.

Structure
REQ-026 State encodings and the constant NUM_REQ=8 SHALL live in the shared package arb_pkg.
REQ-027 Winner selection SHALL use one combinational sub-module, prio_enc8: 8-bit vector in, 3-bit highest-set index and valid out, with bit 7 as highest priority; it is instantiated twice (masked and unmasked).
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-029 Bench SHALL cover: after reset, req=8'h88 -> gnt=8'h80, gnt_id=7 at the next edge; done pulse -> gnt=8'h08, gnt_id=3 at the following edge; done again -> gnt=8'h80.
REQ-030 Bench SHALL cover: req=8'h01 held with no done, MAX_HOLD=16 -> gnt held for 16 cycles, then timeout=1 for one cycle, then gnt=8'h01 again (sole requester re-granted).
REQ-031 Bench SHALL cover: grantee 5 drops req[5] with req=8'h20 -> state IDLE and gnt=0 at the next edge, timeout=0.
REQ-032 Bench SHALL cover: done=1 on the same cycle the hold limit is reached -> normal release, timeout stays 0.
REQ-033 Bench SHALL cover: rst asserted mid-grant with req=8'hFF -> all outputs 0 at the next edge; after rst drops, first grant gnt=8'h80.
REQ-034 Bench SHALL cover: random req and done for 10k cycles, checking one-hot gnt, gnt_id/gnt consistency, and no requester starved beyond 7*MAX_HOLD cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IdxW    = 3;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/prio_enc8.sv
// Combinational highest-set-bit encoder; bit 7 has the highest priority.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Ascending scan so the last (highest) set bit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i]) idx = IdxW'(i);
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with single-cycle grant latency, done/drop release
// and a hold limit that forcibly revokes a grant after MAX_HOLD cycles.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [8:0] HoldLast = 9'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [8:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    gnt_id_q, gnt_id_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] cand, below, masked;
  logic [IdxW-1:0]    m_idx, a_idx, win_idx;
  logic               m_vld, a_vld;
  logic               req_lost, hit_limit, release_ev;

  // While granted, the current grantee is excluded so a release hands off
  // straight to the next requester.
  assign cand    = (state_q == StGrant) ? (req & ~gnt_q) : req;
  assign below   = (NUM_REQ'(1) << last_q) - NUM_REQ'(1);
  assign masked  = cand & below;
  assign win_idx = m_vld ? m_idx : a_idx;

  prio_enc8 u_enc_masked (
    .vec   (masked),
    .idx   (m_idx),
    .valid (m_vld)
  );

  prio_enc8 u_enc_all (
    .vec   (cand),
    .idx   (a_idx),
    .valid (a_vld)
  );

  assign req_lost   = !req[gnt_id_q];
  assign hit_limit  = (hold_q == HoldLast);
  assign release_ev = done || req_lost || hit_limit;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (a_vld) begin
          state_d  = StGrant;
          gnt_d    = NUM_REQ'(1) << win_idx;
          gnt_id_d = win_idx;
          valid_d  = 1'b1;
          last_d   = win_idx;
          hold_d   = '0;
        end
      end
      StGrant: begin
        if (release_ev) begin
          // Only a pure hold-limit revocation is flagged as a timeout.
          timeout_d = hit_limit && !done && !req_lost;
          if (a_vld) begin
            gnt_d    = NUM_REQ'(1) << win_idx;
            gnt_id_d = win_idx;
            last_d   = win_idx;
            hold_d   = '0;
          end else begin
            state_d  = StIdle;
            gnt_d    = '0;
            gnt_id_d = '0;
            valid_d  = 1'b0;
            hold_d   = '0;
          end
        end else begin
          hold_d = hold_q + 9'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule
